// File: rtl/stage_ex_if.sv
// Execute-stage bundle: decode-side operands in, EX->MEM outputs back, plus the
// stall pair (mem_stall from stage_mem, set_stall towards decode).
// master = the side that drives operands (decode/bench); slave = stage_ex.
interface stage_ex_if #(
  parameter int MEM_OPT_WIDTH = 4,
  parameter int REGADDR_WIDTH = 5
);
  logic [3:0]               alu_opt;
  logic [31:0]              opr_a;
  logic [31:0]              opr_b;
  logic [15:0]              mem_imm;
  logic [31:0]              mem_data_in;
  logic [MEM_OPT_WIDTH-1:0] mem_opt_in;
  logic [REGADDR_WIDTH-1:0] wb_reg_addr_in;
  logic                     mem_stall;
  logic                     set_stall;
  logic [31:0]              alu_result;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_data;
  logic [MEM_OPT_WIDTH-1:0] mem_opt;
  logic [REGADDR_WIDTH-1:0] wb_reg_addr;

  modport master (
    output alu_opt, opr_a, opr_b, mem_imm, mem_data_in, mem_opt_in, wb_reg_addr_in, mem_stall,
    input  set_stall, alu_result, mem_addr, mem_data, mem_opt, wb_reg_addr
  );

  modport slave (
    input  alu_opt, opr_a, opr_b, mem_imm, mem_data_in, mem_opt_in, wb_reg_addr_in, mem_stall,
    output set_stall, alu_result, mem_addr, mem_data, mem_opt, wb_reg_addr
  );
endinterface

// File: rtl/stage_ex.sv
// Execute stage: ALU, load/store effective address, iterative MUL/DIVU/REMU.
// Latency: 1 falling edge for ALU ops; ITER_CYCLES+1 edges of set_stall for MUL/DIVU/REMU.
// Backpressure: mem_stall freezes all output registers; set_stall holds upstream while iterating.
// Ports: clk/rst (sync, active-high, falling-edge state), ex = stage_ex_if.slave bundle.
module stage_ex #(
  parameter int ITER_CYCLES   = 32,
  parameter int MEM_OPT_WIDTH = 4,
  parameter int REGADDR_WIDTH = 5,
  parameter logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = '0
) (
  input  logic     clk,
  input  logic     rst,
  stage_ex_if.slave ex
);
  localparam int CNT_W = $clog2(ITER_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               op_q;
  logic [REGADDR_WIDTH-1:0] dest_q;
  // Shared iteration registers.
  //   MUL : r_acc = partial product, r_x = multiplicand (<<1), r_y = multiplier (>>1)
  //   DIV : r_acc = partial remainder, r_x = dividend shifting out / quotient shifting in, r_y = divisor
  logic [31:0] r_acc, r_x, r_y;

  logic [31:0] alu_res;
  logic [31:0] eff_addr;
  logic        is_iter;
  logic [31:0] mul_next;
  logic [32:0] div_sh;
  logic [32:0] div_sub;
  logic        div_ge;
  logic [31:0] iter_res;

  assign ex.set_stall = (state != ST_IDLE);
  assign is_iter      = (ex.alu_opt == OP_MUL) || (ex.alu_opt == OP_DIVU) || (ex.alu_opt == OP_REMU);
  assign eff_addr     = ex.opr_a + {{16{ex.mem_imm[15]}}, ex.mem_imm};

  always_comb begin
    alu_res = '0;
    case (ex.alu_opt)
      4'd0:    alu_res = ex.opr_a + ex.opr_b;
      4'd1:    alu_res = ex.opr_a - ex.opr_b;
      4'd2:    alu_res = ex.opr_a & ex.opr_b;
      4'd3:    alu_res = ex.opr_a | ex.opr_b;
      4'd4:    alu_res = ex.opr_a ^ ex.opr_b;
      4'd5:    alu_res = ~(ex.opr_a | ex.opr_b);
      4'd6:    alu_res = {31'd0, $signed(ex.opr_a) < $signed(ex.opr_b)};
      4'd7:    alu_res = {31'd0, ex.opr_a < ex.opr_b};
      4'd8:    alu_res = ex.opr_a << ex.opr_b[4:0];
      4'd9:    alu_res = ex.opr_a >> ex.opr_b[4:0];
      4'd10:   alu_res = $unsigned($signed(ex.opr_a) >>> ex.opr_b[4:0]);
      4'd11:   alu_res = {ex.opr_b[15:0], 16'h0000};
      4'd15:   alu_res = ex.opr_a;
      default: alu_res = '0;
    endcase
  end

  // One radix-2 step. Restoring divide by zero naturally yields all-ones
  // quotient and remainder == dividend, so no special case is needed.
  always_comb begin
    mul_next = r_acc + (r_y[0] ? r_x : 32'd0);
    div_sh   = {r_acc, r_x[31]};
    div_sub  = div_sh - {1'b0, r_y};
    div_ge   = (div_sh >= {1'b0, r_y});
    iter_res = (op_q == OP_DIVU) ? r_x : r_acc;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      op_q           <= '0;
      dest_q         <= '0;
      r_acc          <= '0;
      r_x            <= '0;
      r_y            <= '0;
      ex.alu_result  <= '0;
      ex.mem_addr    <= '0;
      ex.mem_data    <= '0;
      ex.mem_opt     <= MEM_OPT_NONE;
      ex.wb_reg_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ex.mem_stall) begin
            ex.mem_addr <= eff_addr;
            ex.mem_data <= ex.mem_data_in;
            if (is_iter) begin
              op_q           <= ex.alu_opt;
              dest_q         <= ex.wb_reg_addr_in;
              r_acc          <= '0;
              r_x            <= ex.opr_a;
              r_y            <= ex.opr_b;
              cnt            <= CNT_W'(ITER_CYCLES);
              state          <= ST_BUSY;
              ex.alu_result  <= '0;
              ex.wb_reg_addr <= '0;
              ex.mem_opt     <= MEM_OPT_NONE;
            end else begin
              ex.alu_result  <= alu_res;
              ex.wb_reg_addr <= ex.wb_reg_addr_in;
              ex.mem_opt     <= ex.mem_opt_in;
            end
          end
        end
        ST_BUSY: begin
          // Iterates regardless of mem_stall; outputs keep the bubble.
          if (op_q == OP_MUL) begin
            r_acc <= mul_next;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
          end else begin
            r_acc <= div_ge ? div_sub[31:0] : div_sh[31:0];
            r_x   <= {r_x[30:0], div_ge};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!ex.mem_stall) begin
            ex.alu_result  <= iter_res;
            ex.wb_reg_addr <= dest_q;
            ex.mem_opt     <= MEM_OPT_NONE;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: one task per scenario, hand-computed expectations.
// DUT state moves on the falling edge; the bench drives and samples 1ns after it.
module tb_stage_ex;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  stage_ex_if ex_if ();

  stage_ex dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex_if)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest);
    ex_if.alu_opt        = op;
    ex_if.opr_a          = a;
    ex_if.opr_b          = b;
    ex_if.wb_reg_addr_in = dest;
  endtask

  // Starts an iterative op and waits (bounded) for set_stall to drop.
  task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] dest, output logic [31:0] res,
                            output logic [4:0] res_dest, output int stall_edges,
                            output bit bubble_ok, output bit timed_out);
    drive(op, a, b, dest);
    ex_if.mem_opt_in = 4'h3;
    stall_edges = 0;
    bubble_ok   = 1'b1;
    timed_out   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ex_if.set_stall === 1'b1) begin
        stall_edges++;
        if (ex_if.wb_reg_addr !== 5'd0 || ex_if.mem_opt !== 4'd0) bubble_ok = 1'b0;
      end else begin
        timed_out = 1'b0;
        break;
      end
    end
    res      = ex_if.alu_result;
    res_dest = ex_if.wb_reg_addr;
    ex_if.mem_opt_in = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_if.mem_stall      = 1'b0;
    ex_if.mem_imm        = 16'h0004;
    ex_if.mem_data_in    = 32'h1234_5678;
    ex_if.mem_opt_in     = 4'h5;
    drive(4'd0, 32'd9, 32'd9, 5'd7);
    tick();
    tick();
    total++;
    if (ex_if.alu_result !== 32'd0 || ex_if.mem_addr !== 32'd0 || ex_if.mem_data !== 32'd0 ||
        ex_if.mem_opt !== 4'd0 || ex_if.wb_reg_addr !== 5'd0 || ex_if.set_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset: got res=%h addr=%h data=%h opt=%h wb=%0d stall=%b, want all zero",
               ex_if.alu_result, ex_if.mem_addr, ex_if.mem_data, ex_if.mem_opt,
               ex_if.wb_reg_addr, ex_if.set_stall);
    end
    rst = 1'b0;
    ex_if.mem_opt_in  = 4'h0;
    ex_if.mem_imm     = 16'h0000;
    ex_if.mem_data_in = 32'h0;
  endtask

  task automatic test_add();
    drive(4'd0, 32'd5, 32'd7, 5'd3);
    tick();
    total++;
    if (ex_if.alu_result !== 32'd12 || ex_if.wb_reg_addr !== 5'd3 || ex_if.set_stall !== 1'b0) begin
      bad++;
      $display("FAIL add: got res=%0d wb=%0d stall=%b, want 12/3/0",
               ex_if.alu_result, ex_if.wb_reg_addr, ex_if.set_stall);
    end
  endtask

  // Back-to-back single-cycle ops, one result checked per edge.
  task automatic test_alu_ops();
    logic [3:0]  ops [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15, 4'd0};
    logic [31:0] va  [13] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0F0F0F,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000,
                              32'h0, 32'hCAFEF00D, 32'hFFFFFFFF};
    logic [31:0] vb  [13] = '{32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'hF0F00000,
                              32'd1, 32'd1, 32'h24, 32'd4, 32'd4, 32'hABCD1234, 32'd0, 32'd2};
    logic [31:0] exp [13] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'h0000F0F0,
                              32'd1, 32'd0, 32'h10, 32'h08000000, 32'hF8000000, 32'h12340000,
                              32'hCAFEF00D, 32'd1};
    for (int i = 0; i < 13; i++) begin
      drive(ops[i], va[i], vb[i], 5'(i + 1));
      tick();
      total++;
      if (ex_if.alu_result !== exp[i] || ex_if.wb_reg_addr !== 5'(i + 1)) begin
        bad++;
        $display("FAIL alu_op%0d: got res=%h wb=%0d, want %h/%0d",
                 ops[i], ex_if.alu_result, ex_if.wb_reg_addr, exp[i], i + 1);
      end
    end
  endtask

  task automatic test_store();
    drive(4'd0, 32'h80000000, 32'd0, 5'd0);
    ex_if.mem_imm     = 16'hFFFC;
    ex_if.mem_data_in = 32'hDEADBEEF;
    ex_if.mem_opt_in  = 4'h2;
    tick();
    total++;
    if (ex_if.mem_addr !== 32'h7FFFFFFC || ex_if.mem_data !== 32'hDEADBEEF || ex_if.mem_opt !== 4'h2) begin
      bad++;
      $display("FAIL store: got addr=%h data=%h opt=%h, want 7ffffffc/deadbeef/2",
               ex_if.mem_addr, ex_if.mem_data, ex_if.mem_opt);
    end
    ex_if.mem_imm     = 16'h0010;
    ex_if.mem_opt_in  = 4'h1;
    drive(4'd0, 32'h00001000, 32'd0, 5'd0);
    tick();
    total++;
    if (ex_if.mem_addr !== 32'h00001010 || ex_if.mem_opt !== 4'h1) begin
      bad++;
      $display("FAIL load_addr: got addr=%h opt=%h, want 00001010/1", ex_if.mem_addr, ex_if.mem_opt);
    end
    ex_if.mem_imm     = 16'h0;
    ex_if.mem_data_in = 32'h0;
    ex_if.mem_opt_in  = 4'h0;
  endtask

  task automatic test_divu();
    logic [31:0] res;
    logic [4:0]  rd;
    int          se;
    bit          bub, to;
    run_muldiv(4'd13, 32'd100, 32'd7, 5'd5, res, rd, se, bub, to);
    total++;
    if (to || se != 33) begin
      bad++;
      $display("FAIL divu_stall: got stall_edges=%0d timeout=%0d, want 33/0", se, to);
    end
    total++;
    if (!bub) begin
      bad++;
      $display("FAIL divu_bubble: got non-bubble output while stalled, want wb=0 opt=0");
    end
    total++;
    if (res !== 32'd14 || rd !== 5'd5 || ex_if.mem_opt !== 4'd0) begin
      bad++;
      $display("FAIL divu_result: got res=%0d wb=%0d opt=%h, want 14/5/0", res, rd, ex_if.mem_opt);
    end
  endtask

  task automatic test_muldiv_edge();
    logic [3:0]  ops  [4] = '{4'd14, 4'd13, 4'd12, 4'd12};
    logic [31:0] va   [4] = '{32'd100, 32'd100, 32'hFFFFFFFF, 32'd6};
    logic [31:0] vb   [4] = '{32'd0, 32'd0, 32'd3, 32'd7};
    logic [31:0] exp  [4] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd42};
    logic [31:0] res;
    logic [4:0]  rd;
    int          se;
    bit          bub, to;
    for (int i = 0; i < 4; i++) begin
      run_muldiv(ops[i], va[i], vb[i], 5'(i + 10), res, rd, se, bub, to);
      total++;
      if (to || se != 33 || res !== exp[i] || rd !== 5'(i + 10)) begin
        bad++;
        $display("FAIL muldiv_op%0d_%0d: got res=%h wb=%0d edges=%0d, want %h/%0d/33",
                 ops[i], i, res, rd, se, exp[i], i + 10);
      end
    end
  endtask

  task automatic test_mem_stall();
    drive(4'd0, 32'd1, 32'd2, 5'd4);
    tick();
    ex_if.mem_stall = 1'b1;
    drive(4'd0, 32'd10, 32'd20, 5'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ex_if.alu_result !== 32'd3 || ex_if.wb_reg_addr !== 5'd4) begin
        bad++;
        $display("FAIL stall_hold%0d: got res=%0d wb=%0d, want 3/4", i, ex_if.alu_result, ex_if.wb_reg_addr);
      end
    end
    ex_if.mem_stall = 1'b0;
    tick();
    total++;
    if (ex_if.alu_result !== 32'd30 || ex_if.wb_reg_addr !== 5'd6) begin
      bad++;
      $display("FAIL stall_release: got res=%0d wb=%0d, want 30/6", ex_if.alu_result, ex_if.wb_reg_addr);
    end
    // mem_stall from just after acceptance: 32 BUSY edges plus one held DONE edge.
    drive(4'd13, 32'd100, 32'd7, 5'd5);
    tick();
    ex_if.mem_stall = 1'b1;
    for (int i = 0; i < 33; i++) tick();
    total++;
    if (ex_if.set_stall !== 1'b1 || ex_if.wb_reg_addr !== 5'd0) begin
      bad++;
      $display("FAIL done_hold: got stall=%b wb=%0d, want 1/0", ex_if.set_stall, ex_if.wb_reg_addr);
    end
    ex_if.mem_stall = 1'b0;
    tick();
    total++;
    if (ex_if.set_stall !== 1'b0 || ex_if.alu_result !== 32'd14 || ex_if.wb_reg_addr !== 5'd5) begin
      bad++;
      $display("FAIL done_release: got stall=%b res=%0d wb=%0d, want 0/14/5",
               ex_if.set_stall, ex_if.alu_result, ex_if.wb_reg_addr);
    end
    drive(4'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_reset_mid();
    bit leaked;
    drive(4'd13, 32'd100, 32'd7, 5'd5);
    ex_if.mem_opt_in = 4'h3;
    tick();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    total++;
    if (ex_if.set_stall !== 1'b0 || ex_if.wb_reg_addr !== 5'd0 || ex_if.mem_opt !== 4'd0 ||
        ex_if.alu_result !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: got stall=%b wb=%0d opt=%h res=%h, want 0/0/0/0",
               ex_if.set_stall, ex_if.wb_reg_addr, ex_if.mem_opt, ex_if.alu_result);
    end
    rst = 1'b0;
    ex_if.mem_opt_in = 4'h0;
    drive(4'd0, 32'd0, 32'd0, 5'd0);
    leaked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ex_if.wb_reg_addr !== 5'd0 || ex_if.set_stall !== 1'b0) leaked = 1'b1;
    end
    total++;
    if (leaked) begin
      bad++;
      $display("FAIL reset_mid_leak: got a result or stall after abort, want none");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ex_if.mem_stall = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_store();
    test_divu();
    test_muldiv_edge();
    test_mem_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
